// File: rtl/cnt_fsm_pkg.sv
// cnt_fsm_pkg: shared state encoding for the multi-channel run counter
package cnt_fsm_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } cnt_state_t;
endpackage

// File: rtl/cnt_fsm_chan.sv
// cnt_fsm_chan: one start/stop run-counter channel with windowed stop, wrap/saturate and clear
module cnt_fsm_chan
    import cnt_fsm_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WIN_LO = 5,
    parameter int WIN_HI = 6,
    parameter bit WRAP   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    output logic [WIDTH-1:0]   counter,
    output logic [STATE_W-1:0] state,
    output logic               done,
    output logic               done_pulse,
    output logic               overflow
);
    localparam logic [WIDTH-1:0] LO  = WIDTH'(WIN_LO);
    localparam logic [WIDTH-1:0] HI  = WIDTH'(WIN_HI);
    localparam logic [WIDTH-1:0] MAX = '1;

    if (WIDTH < 2) begin : g_chk_width
        $error("cnt_fsm_chan: WIDTH must be at least 2");
    end
    if (WIN_LO > WIN_HI) begin : g_chk_win_order
        $error("cnt_fsm_chan: WIN_LO must not exceed WIN_HI");
    end
    if (WIN_LO < 0 || longint'(WIN_HI) >= (longint'(1) << WIDTH)) begin : g_chk_win_range
        $error("cnt_fsm_chan: stop window must fit in WIDTH bits");
    end

    cnt_state_t       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             dp_q, dp_d;
    logic             in_win;
    logic             at_max;

    // The window test and overflow use the count before this cycle's increment.
    assign in_win = (cnt_q >= LO) && (cnt_q <= HI);
    assign at_max = cnt_q == MAX;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        dp_d    = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = start ? INIT : IDLE;
                end
                INIT: begin
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
                RUN: begin
                    cnt_d   = at_max ? (WRAP ? '0 : MAX) : cnt_q + 1'b1;
                    ovf_d   = ovf_q | at_max;
                    state_d = (stop && in_win) ? DONE : RUN;
                    dp_d    = stop && in_win;
                end
                DONE: state_d = DONE;
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            dp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            dp_q    <= dp_d;
        end
    end

    assign counter    = cnt_q;
    assign state      = state_q;
    assign done       = state_q == DONE;
    assign done_pulse = dp_q;
    assign overflow   = ovf_q;
endmodule

// File: rtl/cnt_fsm_array.sv
// cnt_fsm_array: NCH independent start/stop run counters sharing one clock and reset
module cnt_fsm_array
    import cnt_fsm_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int WIDTH  = 8,
    parameter int WIN_LO = 5,
    parameter int WIN_HI = 6,
    parameter bit WRAP   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         start,
    input  logic [NCH-1:0]         stop,
    input  logic [NCH-1:0]         clear,
    output logic [NCH*WIDTH-1:0]   counter,
    output logic [NCH*STATE_W-1:0] state,
    output logic [NCH-1:0]         done,
    output logic [NCH-1:0]         done_pulse,
    output logic [NCH-1:0]         overflow
);
    if (NCH < 1) begin : g_chk_nch
        $error("cnt_fsm_array: NCH must be at least 1");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        cnt_fsm_chan #(
            .WIDTH (WIDTH),
            .WIN_LO(WIN_LO),
            .WIN_HI(WIN_HI),
            .WRAP  (WRAP)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .start     (start[i]),
            .stop      (stop[i]),
            .clear     (clear[i]),
            .counter   (counter[i*WIDTH +: WIDTH]),
            .state     (state[i*STATE_W +: STATE_W]),
            .done      (done[i]),
            .done_pulse(done_pulse[i]),
            .overflow  (overflow[i])
        );
    end
endmodule

// File: tb/tb_cnt_fsm_array.sv
// tb_cnt_fsm_array: table vectors, hand sequences and a scoreboarded channel model
module tb_cnt_fsm_array;
    import cnt_fsm_pkg::*;
    localparam int NCH = 4;
    localparam int W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NCH-1:0] start = '0, stop = '0, clear = '0;
    logic [NCH*W-1:0] counter;
    logic [NCH*2-1:0] state;
    logic [NCH-1:0] done, done_pulse, overflow;

    logic ws_start = 1'b0, ws_stop = 1'b0, ws_clear = 1'b0;
    logic [2:0] w_cnt, s_cnt;
    logic [1:0] w_st, s_st;
    logic w_dn, w_dp, w_ov, s_dn, s_dp, s_ov;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [NCH*W-1:0] cnt;
        logic [NCH*2-1:0] st;
        logic [NCH-1:0]   dn, dp, ov;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic st, sp, cl;
        logic [1:0] e_st;
        logic [7:0] e_cnt;
        logic e_dn, e_dp;
    } vec_t;
    vec_t tv[13];

    int   m_st[NCH];
    int   m_cnt[NCH];
    logic m_ovf[NCH];
    logic m_dp[NCH];

    always #5 clk = ~clk;

    cnt_fsm_array #(.NCH(NCH), .WIDTH(W), .WIN_LO(5), .WIN_HI(6), .WRAP(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .counter(counter), .state(state), .done(done), .done_pulse(done_pulse), .overflow(overflow)
    );
    cnt_fsm_array #(.NCH(1), .WIDTH(3), .WIN_LO(6), .WIN_HI(6), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .start(ws_start), .stop(ws_stop), .clear(ws_clear),
        .counter(w_cnt), .state(w_st), .done(w_dn), .done_pulse(w_dp), .overflow(w_ov)
    );
    cnt_fsm_array #(.NCH(1), .WIDTH(3), .WIN_LO(6), .WIN_HI(6), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .start(ws_start), .stop(ws_stop), .clear(ws_clear),
        .counter(s_cnt), .state(s_st), .done(s_dn), .done_pulse(s_dp), .overflow(s_ov)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic st, sp, cl, input logic [1:0] e_st,
                               input logic [7:0] e_cnt, input logic e_dn, e_dp);
        vec_t r;
        r.st = st; r.sp = sp; r.cl = cl;
        r.e_st = e_st; r.e_cnt = e_cnt; r.e_dn = e_dn; r.e_dp = e_dp;
        return r;
    endfunction

    // Advance the reference model with the inputs about to be clocked in.
    task automatic predict();
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            if (!rst || clear[c]) begin
                m_st[c] = 0; m_cnt[c] = 0; m_ovf[c] = 1'b0; m_dp[c] = 1'b0;
            end else begin
                m_dp[c] = 1'b0;
                if (m_st[c] == 0) begin
                    m_cnt[c] = 0;
                    if (start[c]) m_st[c] = 1;
                end else if (m_st[c] == 1) begin
                    m_cnt[c] = 0; m_ovf[c] = 1'b0; m_st[c] = 2;
                end else if (m_st[c] == 2) begin
                    if (stop[c] && m_cnt[c] >= 5 && m_cnt[c] <= 6) begin
                        m_st[c] = 3; m_dp[c] = 1'b1;
                    end
                    m_cnt[c] = m_cnt[c] + 1;
                    if (m_cnt[c] == 256) begin
                        m_cnt[c] = 0; m_ovf[c] = 1'b1;
                    end
                end
            end
            e.cnt[c*W +: W] = m_cnt[c][W-1:0];
            e.st[2*c +: 2]  = m_st[c][1:0];
            e.dn[c] = m_st[c] == 3;
            e.dp[c] = m_dp[c];
            e.ov[c] = m_ovf[c];
        end
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        predict();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_counter", counter, e.cnt);
        chk("sb_state", state, e.st);
        chk("sb_done", done, e.dn);
        chk("sb_done_pulse", done_pulse, e.dp);
        chk("sb_overflow", overflow, e.ov);
    endtask

    initial begin
        foreach (m_st[c]) begin
            m_st[c] = 0; m_cnt[c] = 0; m_ovf[c] = 1'b0; m_dp[c] = 1'b0;
        end
        tv[0]  = v(1, 0, 0, 2'd1, 8'd0, 0, 0);
        tv[1]  = v(0, 0, 0, 2'd2, 8'd0, 0, 0);
        tv[2]  = v(0, 1, 0, 2'd2, 8'd1, 0, 0);
        tv[3]  = v(0, 1, 0, 2'd2, 8'd2, 0, 0);
        tv[4]  = v(0, 1, 0, 2'd2, 8'd3, 0, 0);
        tv[5]  = v(0, 1, 0, 2'd2, 8'd4, 0, 0);
        tv[6]  = v(0, 1, 0, 2'd2, 8'd5, 0, 0);
        tv[7]  = v(0, 1, 0, 2'd3, 8'd6, 1, 1);
        tv[8]  = v(0, 1, 0, 2'd3, 8'd6, 1, 0);
        tv[9]  = v(1, 1, 0, 2'd3, 8'd6, 1, 0);
        tv[10] = v(0, 0, 1, 2'd0, 8'd0, 0, 0);
        tv[11] = v(1, 0, 0, 2'd1, 8'd0, 0, 0);
        tv[12] = v(0, 0, 0, 2'd2, 8'd0, 0, 0);

        rst = 1'b0;
        start = '1; stop = '1;
        tick();
        tick();
        chk("rst_wrap_cnt", w_cnt, 0);
        chk("rst_wrap_state", w_st, IDLE);
        chk("rst_sat_ovf", s_ov, 0);
        start = '0; stop = '0;
        rst = 1'b1;

        // Basic run on channel 0, other channels idle
        for (int i = 0; i < 13; i++) begin
            start = {3'b000, tv[i].st};
            stop  = {3'b000, tv[i].sp};
            clear = {3'b000, tv[i].cl};
            tick();
            chk("tv_state", state[1:0], tv[i].e_st);
            chk("tv_counter", counter[7:0], tv[i].e_cnt);
            chk("tv_done", done[0], tv[i].e_dn);
            chk("tv_done_pulse", done_pulse[0], tv[i].e_dp);
            chk("tv_overflow", overflow[0], 0);
        end
        start = '0; stop = '0; clear = '0;

        // Window miss: stop only at counter 4 and 7
        repeat (4) tick();
        stop[0] = 1'b1; tick();
        stop[0] = 1'b0; tick(); tick();
        stop[0] = 1'b1; tick();
        stop[0] = 1'b0;
        chk("miss_state", state[1:0], RUN);
        chk("miss_counter", counter[7:0], 8);

        // Clear beats stop at counter 5
        clear[0] = 1'b1; tick();
        clear[0] = 1'b0; start[0] = 1'b1; tick();
        start[0] = 1'b0; tick();
        repeat (5) tick();
        chk("cs_pre_counter", counter[7:0], 5);
        stop[0] = 1'b1; clear[0] = 1'b1; tick();
        chk("cs_state", state[1:0], IDLE);
        chk("cs_counter", counter[7:0], 0);
        chk("cs_done", done[0], 0);
        stop[0] = 1'b0; clear[0] = 1'b0; tick();
        chk("cs_done_after", done[0], 0);

        // Reset mid-run
        start[0] = 1'b1; tick();
        start[0] = 1'b0;
        repeat (4) tick();
        chk("mr_pre_counter", counter[7:0], 3);
        rst = 1'b0; tick();
        rst = 1'b1;
        chk("mr_state", state[1:0], IDLE);
        chk("mr_counter", counter[7:0], 0);
        chk("mr_overflow", overflow[0], 0);

        // Wrap vs saturate on the 3-bit instances
        ws_start = 1'b1; tick();
        ws_start = 1'b0;
        chk("ws_init", w_st, INIT);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("wrap_state", w_st, RUN);
            chk("wrap_counter", w_cnt, k % 8);
            chk("wrap_overflow", w_ov, k >= 8);
            chk("sat_counter", s_cnt, (k > 7) ? 7 : k);
            chk("sat_overflow", s_ov, k >= 8);
        end

        // Channel independence with continuous clear on channel 1
        clear = '1; tick();
        clear = '0;
        for (int c = 0; c < 40; c++) begin
            start[0] = c == 2;
            start[2] = c == 7;
            start[1] = 1'b1;
            clear[1] = 1'b1;
            start[3] = 1'($urandom_range(0, 1));
            clear[3] = $urandom_range(0, 9) == 0;
            stop     = 4'($urandom_range(0, 15));
            tick();
            chk("ind_ch1_idle", state[3:2], IDLE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cnt_fsm_array.md
# cnt_fsm_array

Parametrised, multi-channel start/stop run counter. It generalises the single-channel IDLE/INIT/RUN/DONE counter in four ways: configurable counter width, a configurable stop window, wrap or saturate at overflow, and a per-channel clear that returns a finished channel to IDLE. It sits beside the control FSMs in the demo design and provides NCH independent measurement channels that share one clock and reset.

## Interface
- NCH, 4, number of independent channels (≥1)
- WIDTH, 8, counter width per channel (≥2)
- WIN_LO, 5, lowest counter value at which stop is accepted
- WIN_HI, 6, highest counter value at which stop is accepted (WIN_LO ≤ WIN_HI ≤ 2^WIDTH−1)
- WRAP, 1, 1: counter wraps to 0 at max; 0: counter saturates at max

- clk  input  1  clock
- rst  input  1  reset; synchronous, active-low
- start  input  NCH  per-channel run request, sampled in IDLE
- stop  input  NCH  per-channel stop request, sampled in RUN
- clear  input  NCH  per-channel abort/re-arm
- counter  output  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- state  output  NCH*2  channel i state at bits [2i +: 2]
- done  output  NCH  level; high while the channel is in DONE
- done_pulse  output  NCH  one-cycle strobe on the first cycle the channel is in DONE
- overflow  output  NCH  sticky; set when the counter passes max during RUN

## Operation
- Reset (rst=0 at a clk edge): every channel goes to IDLE, with counter=0, done=0, done_pulse=0, overflow=0. Reset takes priority over all other inputs, including mid-run.
- States and encoding: IDLE=0, INIT=1, RUN=2, DONE=3. Channels are fully independent.
- Priority per channel: rst > clear > state logic.
- clear=1 in any state: next state IDLE, counter←0, overflow←0, done_pulse←0.
- IDLE: counter←0. start=1 → INIT.
- INIT: counter←0, overflow←0; unconditionally → RUN.
- RUN: the counter advances every cycle.
  - counter<max: counter←counter+1.
  - counter=max with WRAP=1: counter←0 and overflow←1.
  - counter=max with WRAP=0: counter holds at max and overflow←1.
  - Exit to DONE when stop=1 and WIN_LO ≤ counter ≤ WIN_HI. The comparison uses the pre-increment value.
  - The counter still advances on the transition cycle.
  - A stop outside the window is ignored.
- DONE: counter and overflow hold. start and stop are ignored. Only clear or rst leave DONE.
- Illegal state: not reachable, since all 4 codes are used. Any default branch goes to IDLE with counter←0.
- done is `state==DONE`. done_pulse is registered: set on the RUN→DONE edge and cleared the following cycle.
- Window compares are unsigned and WIDTH bits wide. Wrap arithmetic is modulo 2^WIDTH.

## Timing
- Every output is a registered output. There is no combinational path from any input to any output.
- With start=1 in cycle 0 (channel in IDLE):
  - cycle 1: state=INIT.
  - cycle 2: state=RUN, counter=0.
  - cycle 2+k: counter=k while in RUN.
- With stop=1 in a cycle where counter=c is inside the window:
  - next cycle: state=DONE, counter=c+1, done=1, done_pulse=1.
  - the cycle after: done_pulse=0.
- clear in cycle n → IDLE with counter=0 in cycle n+1. If start=1 in cycle n+1, INIT follows in cycle n+2.
- clear and stop in the same cycle: clear wins and DONE is not entered.
- start held high while in DONE has no effect. After a clear, a still-high start is accepted in the next IDLE cycle.

## Structure
- The shared package `cnt_fsm_pkg` holds:
  - the typedef enum logic [1:0] `cnt_state_t` with IDLE/INIT/RUN/DONE;
  - a localparam for the state width.
- Sub-module `cnt_fsm_chan` holds one channel's FSM, counter, overflow and done_pulse logic, using the same parameters without NCH.
- The top level instantiates `cnt_fsm_chan` NCH times in a generate loop and packs the outputs.
- Elaboration-time assertions check the parameter constraints.

## Test plan
- Reset mid-run: NCH=1, WIDTH=8. start in cycle 0, rst=0 in cycle 5 → cycle 6: state=IDLE, counter=0, overflow=0.
- Basic run (defaults): start in cycle 0, stop held high from cycle 2 → stop is ignored until counter=5 (cycle 7); cycle 8: DONE, counter=6, done_pulse=1 for exactly one cycle; counter stays 6 thereafter.
- Window miss: stop pulsed only when counter=4 and when counter=7 → channel stays in RUN and counter keeps incrementing.
- Wrap vs saturate: WIDTH=3, WIN_LO=WIN_HI=6, no stop, run for 10 cycles of RUN.
  - WRAP=1 → counter sequence 0..7,0,1; overflow=1 from the cycle counter shows 0 after 7.
  - WRAP=0 → counter sticks at 7; overflow=1.
- Clear and priority:
  - In DONE, clear=1 → IDLE with counter=0 next cycle, then a new start runs normally with overflow=0.
  - clear and stop in the same cycle at counter=5 → IDLE, done is never asserted.
- Channel independence: NCH=4, start channels 0 and 2 at different cycles, clear channel 1 continuously → each channel's counter and state match a per-channel model, and channel 1 stays in IDLE.
